// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the RV32I subset core: walks fetch/decode/
// execute/memory/write-back, gates the architectural write strobes and counts retirements.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [6:0]       Opcode,
  input  logic             BranchTaken,
  input  logic             MemReady,
  output logic             InstrReq,
  output logic             DataReq,
  output logic             MemWriteEn,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       PCSel,
  output logic             RegWriteEn,
  output logic [2:0]       State,
  output logic             Illegal,
  output logic             Fault,
  output logic [CNT_W-1:0] InstrCount
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3, MEM = 3'd4, WB = 3'd5, HALT = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_LOAD, C_ALUI, C_JALR, C_STORE, C_BRANCH, C_LUI, C_JAL
  } cls_t;

  localparam logic [7:0] WAIT_LIM = 8'(MEM_TIMEOUT - 1);

  state_t     state;
  cls_t       cls;
  logic [7:0] waitCnt;

  cls_t   decCls;
  logic   decOk;
  logic   retire;
  state_t nextRet;

  always_comb begin
    decOk  = 1'b1;
    decCls = C_R;
    case (Opcode)
      7'b0110011: decCls = C_R;
      7'b0000011: decCls = C_LOAD;
      7'b0010011: decCls = C_ALUI;
      7'b1100111: decCls = C_JALR;
      7'b0100011: decCls = C_STORE;
      7'b1100011: decCls = C_BRANCH;
      7'b0110111: decCls = C_LUI;
      7'b1101111: decCls = C_JAL;
      default:    decOk  = 1'b0;
    endcase
  end

  // A store retires on its MemReady cycle, so that one PC strobe follows MemReady like IRWrite.
  assign retire  = (state == EXEC && cls == C_BRANCH) ||
                   (state == MEM  && cls == C_STORE && MemReady) ||
                   (state == WB);
  assign nextRet = Start ? FETCH : IDLE;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= IDLE;
      cls        <= C_R;
      waitCnt    <= '0;
      Illegal    <= 1'b0;
      Fault      <= 1'b0;
      InstrCount <= '0;
    end else begin
      if (retire) InstrCount <= InstrCount + CNT_W'(1);
      case (state)
        IDLE: begin
          waitCnt <= '0;
          if (Start) state <= FETCH;
        end
        FETCH, MEM: begin
          if (MemReady) begin
            waitCnt <= '0;
            if (state == FETCH)     state <= DECODE;
            else if (cls == C_LOAD) state <= WB;
            else                    state <= nextRet;
          end else if (waitCnt == WAIT_LIM) begin
            state <= HALT;
            Fault <= 1'b1;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        DECODE: begin
          if (decOk) begin
            cls   <= decCls;
            state <= EXEC;
          end else begin
            state   <= HALT;
            Illegal <= 1'b1;
          end
        end
        EXEC: begin
          waitCnt <= '0;
          case (cls)
            C_BRANCH:       state <= nextRet;
            C_LOAD, C_STORE: state <= MEM;
            default:        state <= WB;
          endcase
        end
        WB:      state <= nextRet;
        default: state <= HALT;
      endcase
    end
  end

  // Strobes decode from registered state/class only; reset kills them at once.
  always_comb begin
    InstrReq   = (state == FETCH);
    IRWrite    = (state == FETCH) && MemReady;
    DataReq    = (state == MEM);
    MemWriteEn = (state == MEM) && (cls == C_STORE);
    RegWriteEn = (state == WB);
    PCWrite    = retire;
    PCSel      = 2'b00;
    if (state == EXEC && cls == C_BRANCH && BranchTaken) PCSel = 2'b01;
    if (state == WB && cls == C_JAL)                     PCSel = 2'b01;
    if (state == WB && cls == C_JALR)                    PCSel = 2'b10;
  end

  assign State = state;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench: each issued instruction pushes its expected retirement record;
// the monitor pops and compares when the sequencer strobes PCWrite.
module tb_multicycle_sequencer;
  localparam int CW = 4;

  logic          Clk = 1'b0, Rst_n = 1'b0, Start = 1'b0, BranchTaken = 1'b0, MemReady = 1'b0;
  logic [6:0]    Opcode = 7'b0110011;
  logic          InstrReq, DataReq, MemWriteEn, IRWrite, PCWrite, RegWriteEn, Illegal, Fault;
  logic [1:0]    PCSel;
  logic [2:0]    State;
  logic [CW-1:0] InstrCount;

  multicycle_sequencer #(.MEM_TIMEOUT(15), .CNT_W(CW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Opcode(Opcode), .BranchTaken(BranchTaken),
    .MemReady(MemReady), .InstrReq(InstrReq), .DataReq(DataReq), .MemWriteEn(MemWriteEn),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSel(PCSel), .RegWriteEn(RegWriteEn),
    .State(State), .Illegal(Illegal), .Fault(Fault), .InstrCount(InstrCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0] pcSel;
    logic       regWe;
    int         lat;
    int         dReq;
    int         mWr;
  } exp_t;

  exp_t sb[$];
  int   total = 0, bad = 0;
  int   fd = 0, md = 0, reqCnt = 0, expCnt = 0;
  int   lat = 0, dReqN = 0, mWrN = 0, rwN = 0;
  bit   noise = 1'b0, retired = 1'b0;
  logic [2:0] prevState = 3'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory responder: answers after fd (fetch) or md (data) wait cycles.
  always @(negedge Clk) begin
    if (InstrReq || DataReq) begin
      MemReady = (reqCnt == (InstrReq ? fd : md));
      reqCnt   = MemReady ? 0 : reqCnt + 1;
    end else begin
      MemReady = noise;
      reqCnt   = 0;
    end
  end

  always @(negedge Clk) begin
    exp_t e;
    #1;
    if (!Rst_n) begin
      lat = 0; dReqN = 0; mWrN = 0; rwN = 0; prevState = 3'd0;
    end else begin
      if (State == 3'd1 && prevState != 3'd1) begin
        lat = 1; dReqN = 0; mWrN = 0; rwN = 0;
      end else lat++;
      prevState = State;
      if (DataReq)    dReqN++;
      if (MemWriteEn) mWrN++;
      if (RegWriteEn) rwN++;
      if (!PCWrite) chk("pcSelIdle", 32'(PCSel), 32'd0);
      else begin
        if (sb.size() == 0) chk("unexpectedRetire", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("pcSel",   32'(PCSel), 32'(e.pcSel));
          chk("regWe",   32'(RegWriteEn), 32'(e.regWe));
          chk("regWeN",  32'(rwN), 32'(e.regWe));
          chk("latency", 32'(lat), 32'(e.lat));
          chk("dataReqN", 32'(dReqN), 32'(e.dReq));
          chk("memWrN",  32'(mWrN), 32'(e.mWr));
        end
        retired = 1'b1;
      end
    end
  end

  task automatic runInstr(input logic [6:0] op, input logic bt, input int f, input int m,
                          input bit dropStart);
    exp_t e;
    bit isLd, isSt, isBr;
    int n;
    isLd = (op == 7'b0000011);
    isSt = (op == 7'b0100011);
    isBr = (op == 7'b1100011);
    Opcode = op; BranchTaken = bt; fd = f; md = m; Start = 1'b1;
    e.pcSel = isBr ? {1'b0, bt} : (op == 7'b1101111) ? 2'd1 : (op == 7'b1100111) ? 2'd2 : 2'd0;
    e.regWe = !(isBr || isSt);
    e.lat   = (isBr ? 3 : isLd ? 5 : 4) + f + ((isLd || isSt) ? m : 0);
    e.dReq  = (isLd || isSt) ? m + 1 : 0;
    e.mWr   = isSt ? m + 1 : 0;
    sb.push_back(e);
    expCnt++;
    retired = 1'b0;
    n = 0;
    while (!retired && n < 200) begin
      @(posedge Clk); #2; n++;
      if (dropStart && State == 3'd3) Start = 1'b0;
    end
    chk("retired", 32'(retired), 32'd1);
    chk("instrCount", 32'(InstrCount), 32'(expCnt % (1 << CW)));
    chk("nextState", 32'(State), Start ? 32'd1 : 32'd0);
  endtask

  task automatic doReset();
    Rst_n = 1'b0;
    #1;
    chk("rstState", 32'(State), 32'd0);
    chk("rstFlags", {28'd0, Illegal, Fault, InstrReq, DataReq}, 32'd0);
    chk("rstStrobes", {27'd0, MemWriteEn, IRWrite, PCWrite, RegWriteEn, |PCSel}, 32'd0);
    chk("rstCount", 32'(InstrCount), 32'd0);
    sb.delete();
    expCnt = 0;
    Start = 1'b0;
    @(posedge Clk); #2;
    Rst_n = 1'b1;
  endtask

  logic [6:0] tOp [17] = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100011,
                           7'b1101111, 7'b1100111, 7'b0010011, 7'b0110111, 7'b0100011,
                           7'b0000011, 7'b0000011, 7'b0110011, 7'b1100011, 7'b0110011,
                           7'b0110011, 7'b1101111};
  logic       tBt [17] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
  int         tF  [17] = '{0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 14, 0, 0, 3, 0, 0, 0};
  int         tM  [17] = '{0, 3, 0, 0, 0, 0, 0, 0, 0, 2, 0, 14, 0, 0, 0, 0, 0};
  bit         tDr [17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1};

  initial begin
    int n;
    doReset();

    for (int i = 0; i < 17; i++) begin
      noise = (i >= 13);
      runInstr(tOp[i], tBt[i], tF[i], tM[i], tDr[i]);
    end
    noise = 1'b0;

    // Illegal opcode: FETCH, DECODE, then HALT
    Opcode = 7'b1111111; fd = 0; Start = 1'b1; n = 0;
    while (State != 3'd6 && n < 20) begin @(posedge Clk); #2; n++; end
    chk("illegalCycles", 32'(n), 32'd3);
    chk("illegalFlags", {30'd0, Illegal, Fault}, 32'd2);
    noise = 1'b1;
    repeat (4) @(posedge Clk);
    #2;
    chk("haltHold", {28'd0, State, Illegal}, {28'd0, 3'd6, 1'b1});
    chk("haltCount", 32'(InstrCount), 32'(expCnt % (1 << CW)));
    noise = 1'b0;
    doReset();

    // Fetch timeout: 15 silent FETCH cycles fault
    Opcode = 7'b0110011; fd = 1000; Start = 1'b1; n = 0;
    while (State != 3'd6 && n < 40) begin @(posedge Clk); #2; n++; end
    chk("timeoutCycles", 32'(n), 32'd16);
    chk("timeoutFlags", {29'd0, Fault, Illegal, InstrReq}, 32'd4);
    doReset();

    // Reset during WB drops the write strobes immediately
    fd = 0; Start = 1'b1; n = 0;
    while (State != 3'd5 && n < 20) begin @(posedge Clk); #2; n++; end
    chk("reachWb", 32'(RegWriteEn), 32'd1);
    doReset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
